data_memory_pipe: RTL

//  Parametrised data memory with valid/ready request and response channels; successor to the single-cycle data memory.

---
 rtl/dmem_pkg.sv | 28 ++
 rtl/dmem_lsu_align.sv | 71 +++++++
 rtl/data_memory_pipe.sv | 135 +++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the pipelined data memory.
// Access sizes follow the RV32 load/store funct3 encoding.
package dmem_pkg;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    function automatic logic is_legal_size(input logic [2:0] funct3);
        logic legal;
        case (funct3)
            MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU: legal = 1'b1;
            default:                             legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/dmem_lsu_align.sv
// Combinational lane steering: store byte-enable mask and data placement,
// load lane extraction with sign/zero extension, and misalignment detection.
module dmem_lsu_align
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]          funct3,
    input  logic [1:0]          off,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W-1:0]   rdata_raw,
    output logic [DATA_W/8-1:0] mask,
    output logic [DATA_W-1:0]   wdata_al,
    output logic [DATA_W-1:0]   rdata_ext,
    output logic                misaligned
);

    localparam int NLANES = DATA_W / 8;
    localparam logic [NLANES-1:0] ONE_LANE = NLANES'(1);
    localparam logic [NLANES-1:0] TWO_LANE = NLANES'(3);

    logic [DATA_W-1:0] shifted_s;

    assign wdata_al  = wdata << {off, 3'b000};
    assign shifted_s = rdata_raw >> {off, 3'b000};

    // Byte-enable mask and alignment check; misaligned accesses enable no lanes.
    always_comb begin
        mask       = '0;
        misaligned = 1'b0;
        case (funct3)
            MEM_B, MEM_BU: begin
                mask = ONE_LANE << off;
            end
            MEM_H, MEM_HU: begin
                misaligned = off[0];
                if (off[0]) begin
                    mask = '0;
                end else begin
                    mask = TWO_LANE << off;
                end
            end
            MEM_W: begin
                misaligned = (off != 2'b00);
                if (off == 2'b00) begin
                    mask = '1;
                end else begin
                    mask = '0;
                end
            end
            default: begin
                mask       = '0;
                misaligned = 1'b0;
            end
        endcase
    end

    // Load data extension from the selected lane(s).
    always_comb begin
        rdata_ext = '0;
        case (funct3)
            MEM_B:   rdata_ext = {{(DATA_W-8){shifted_s[7]}}, shifted_s[7:0]};
            MEM_H:   rdata_ext = {{(DATA_W-16){shifted_s[15]}}, shifted_s[15:0]};
            MEM_W:   rdata_ext = rdata_raw;
            MEM_BU:  rdata_ext = {{(DATA_W-8){1'b0}}, shifted_s[7:0]};
            MEM_HU:  rdata_ext = {{(DATA_W-16){1'b0}}, shifted_s[15:0]};
            default: rdata_ext = '0;
        endcase
    end

endmodule

// File: rtl/data_memory_pipe.sv
// Byte-addressed data memory with valid/ready request and response channels,
// configurable read latency and a single outstanding transaction.
module data_memory_pipe
    import dmem_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 12,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int DEPTH  = 2 ** (ADDR_W - 2);
    localparam int NLANES = DATA_W / 8;
    // WAIT lasts READ_LAT-1 cycles; the counter exits on its last value.
    localparam logic [2:0] CNT_LAST = (READ_LAT > 1) ? 3'(READ_LAT - 2) : 3'd0;

    dmem_state_e        state_r;
    dmem_state_e        state_s;
    logic [2:0]         cnt_r;
    logic               rsp_valid_r;
    logic [DATA_W-1:0]  rsp_rdata_r;
    logic               rsp_err_r;

    logic [DATA_W-1:0]  mem [DEPTH];

    logic [ADDR_W-3:0]  idx_s;
    logic [1:0]         off_s;
    logic [DATA_W-1:0]  rdata_raw_s;
    logic [NLANES-1:0]  mask_s;
    logic [DATA_W-1:0]  wdata_al_s;
    logic [DATA_W-1:0]  rdata_ext_s;
    logic               misaligned_s;
    logic               err_s;
    logic               fire_s;

    assign idx_s       = req_addr[ADDR_W-1:2];
    assign off_s       = req_addr[1:0];
    assign rdata_raw_s = mem[idx_s];
    assign req_ready   = rst & (state_r == IDLE);
    assign fire_s      = req_valid & req_ready;
    assign err_s       = misaligned_s | ~is_legal_size(req_funct3);

    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

    dmem_lsu_align #(
        .DATA_W     (DATA_W)
    ) u_align (
        .funct3     (req_funct3),
        .off        (off_s),
        .wdata      (req_wdata),
        .rdata_raw  (rdata_raw_s),
        .mask       (mask_s),
        .wdata_al   (wdata_al_s),
        .rdata_ext  (rdata_ext_s),
        .misaligned (misaligned_s)
    );

    // Next-state logic; stores and single-cycle loads skip WAIT.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (fire_s) begin
                    state_s = (req_we || (READ_LAT == 1)) ? RESP : WAIT;
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == CNT_LAST) begin
                    state_s = RESP;
                end else begin
                    state_s = WAIT;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State, latency counter and response registers; response data captured at acceptance.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= IDLE;
            cnt_r       <= 3'd0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= '0;
            rsp_err_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            rsp_valid_r <= (state_s == RESP);
            if (state_r == WAIT) begin
                cnt_r <= cnt_r + 3'd1;
            end else begin
                cnt_r <= 3'd0;
            end
            if (fire_s) begin
                rsp_err_r   <= err_s;
                rsp_rdata_r <= (req_we || err_s) ? '0 : rdata_ext_s;
            end
        end
    end

    // Array write of enabled lanes; contents survive reset.
    always_ff @(posedge clk) begin
        if (fire_s && req_we && !err_s) begin
            for (int i = 0; i < NLANES; i++) begin
                if (mask_s[i]) begin
                    mem[idx_s][8*i +: 8] <= wdata_al_s[8*i +: 8];
                end
            end
        end
    end

endmodule
